// File: rtl/video_scanout.sv
// video_scanout: read-side client of the 16k x 24 video RAM.
// Generates raster timing, prefetches one 24-bit word (6 pixels of 4 bits)
// at a time through a request/grant port and serialises it into pixel indices.
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   pix_ce             pixel clock enable; raster and serialiser advance on it
//   rd_req, rd_addr    read request and word address {col[5:0], row[7:0]}
//   rd_grant           arbiter accepts rd_addr this cycle
//   rd_data            RAM data, valid the clk after rd_grant
//   pixel, de          pixel index (0 outside the active area), display enable
//   hsync, vsync       active-high syncs
//   frame_start        one-clk pulse on the first active pixel of a frame
//   underrun           sticky: a word was needed but had not been fetched
module video_scanout #(
  parameter int unsigned H_ACTIVE = 384,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 32,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 256,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  output logic        rd_req,
  output logic [13:0] rd_addr,
  input  logic        rd_grant,
  input  logic [23:0] rd_data,
  output logic [3:0]  pixel,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        underrun
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned NCOL    = H_ACTIVE / 6;
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);
  localparam int unsigned FCW     = $clog2(NCOL + 1);

  localparam logic [HW-1:0]  HLast  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  HAct   = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  HSyncS = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  HSyncE = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  VLast  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  VAct   = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  VSyncS = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VSyncE = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FCW-1:0] NColL  = FCW'(NCOL);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d, tgt_row;
  logic           active_d, turnover, load, capture, load_ok, fetch_ok;
  logic [23:0]    load_word, nxt_q, shreg_q;
  logic           nxt_valid_q, discard_q;
  logic [FCW-1:0] fcol_q;
  logic [2:0]     sub_q;
  state_e         state_q;

  // Position the raster moves to on the next pix_ce edge.
  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + VW'(1);
    end
  end

  assign active_d = (h_d < HAct) && (v_d < VAct);
  assign turnover = pix_ce && (h_d == HAct);
  assign load     = pix_ce && active_d && (sub_q == 3'd0);

  // A capture racing a line turnover belongs to the finished line: drop it.
  assign capture   = (state_q == StWait) && !discard_q && !turnover;
  assign load_ok   = capture || nxt_valid_q;
  assign load_word = capture ? rd_data : (nxt_valid_q ? nxt_q : '0);

  // In horizontal blanking the fetcher already works on the next line.
  assign tgt_row  = (h_q >= HAct) ? ((v_q == VLast) ? '0 : v_q + VW'(1)) : v_q;
  assign fetch_ok = !nxt_valid_q && (fcol_q < NColL) && (tgt_row < VAct);

  // Fetch FSM with prefetch buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      fcol_q      <= '0;
      nxt_q       <= '0;
      nxt_valid_q <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Never launch on a turnover edge: the column/row would be stale.
          if (fetch_ok && !turnover) begin
            state_q <= StReq;
            rd_req  <= 1'b1;
            rd_addr <= {6'(fcol_q), 8'(tgt_row)};
          end
        end
        StReq: begin
          if (rd_grant) begin
            state_q <= StWait;
            rd_req  <= 1'b0;
          end
        end
        StWait: begin
          state_q   <= StIdle;
          discard_q <= 1'b0;
          if (capture) begin
            fcol_q <= fcol_q + FCW'(1);
            // When the serialiser loads this very edge it takes rd_data directly.
            if (!load) begin
              nxt_q       <= rd_data;
              nxt_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (load) nxt_valid_q <= 1'b0;

      if (turnover) begin
        fcol_q      <= '0;
        nxt_valid_q <= 1'b0;
        if (state_q == StReq) discard_q <= 1'b1;
      end
    end
  end

  // Raster counters, registered raster outputs and pixel serialiser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q         <= HAct;
      v_q         <= VLast;
      pixel       <= '0;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      sub_q       <= '0;
      shreg_q     <= '0;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        h_q         <= h_d;
        v_q         <= v_d;
        de          <= active_d;
        hsync       <= (h_d >= HSyncS) && (h_d < HSyncE);
        vsync       <= (v_d >= VSyncS) && (v_d < VSyncE);
        frame_start <= active_d && (h_d == '0) && (v_d == '0);
        if (active_d) begin
          if (sub_q == 3'd0) begin
            pixel   <= load_word[23:20];
            shreg_q <= {load_word[19:0], 4'h0};
            if (!load_ok) underrun <= 1'b1;
          end else begin
            pixel   <= shreg_q[23:20];
            shreg_q <= {shreg_q[19:0], 4'h0};
          end
          sub_q <= (sub_q == 3'd5) ? 3'd0 : sub_q + 3'd1;
        end else begin
          pixel <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
module tb_video_scanout;

  localparam int HA = 12, HF = 2, HS = 2, HB = 2;
  localparam int VA = 2,  VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_ce = 1'b0;
  logic        rd_grant = 1'b0;
  logic [23:0] rd_data = '0;
  logic        rd_req;
  logic [13:0] rd_addr;
  logic [3:0]  pixel;
  logic        de, hsync, vsync, frame_start, underrun;

  video_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_grant   (rd_grant),
    .rd_data    (rd_data),
    .pixel      (pixel),
    .de         (de),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // RAM with 1-clk read latency.
  logic [23:0] mem [0:16383];
  always @(posedge clk) begin
    if (rd_req && rd_grant) rd_data <= mem[rd_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: raster position plus a one-word buffer between
  // observed RAM transactions and the 6-pixel word slots of each line.
  int          edge_n = 0;
  int          mh, mv, ph, pv, fcol, last_turn, req_rise;
  logic [3:0]  e_pixel;
  logic        e_de, e_hs, e_vs, e_fs, e_ur;
  logic [23:0] word_cur, nxt, pend_d;
  bit          nxt_v, pend_v, pend_ok, prev_req;
  logic [13:0] prev_addr;

  task automatic model_reset();
    mh = HA; mv = VT - 1; ph = mh; pv = mv;
    e_pixel = '0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_ur = 0;
    word_cur = '0; nxt = '0; nxt_v = 0; fcol = 0;
    pend_v = 0; pend_ok = 0; pend_d = '0;
    last_turn = edge_n; req_rise = -1;
    prev_req = 0; prev_addr = '0;
  endtask

  task automatic step(input bit ce, input bit gnt);
    bit cap, cap_ok, load, wok, turn, act;
    logic [23:0] cap_d, word;
    int trow;
    pix_ce = ce;
    rd_grant = gnt;
    @(posedge clk);
    edge_n++;
    if (!reset) begin
      cap = pend_v; cap_d = pend_d; cap_ok = pend_ok;
      ph = mh; pv = mv;
      e_fs = 0; load = 0; turn = 0; act = 0;
      if (ce) begin
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
        act  = (mh < HA) && (mv < VA);
        turn = (mh == HA);
        load = act && (mh % 6 == 0);
        e_de = act;
        e_hs = (mh >= HA + HF) && (mh < HA + HF + HS);
        e_vs = (mv >= VA + VF) && (mv < VA + VF + VS);
        e_fs = act && (mh == 0) && (mv == 0);
      end
      wok = 0; word = '0;
      if (turn) begin
        nxt_v = 0; fcol = 0; last_turn = edge_n;
      end else if (cap && cap_ok) begin
        fcol++;
        if (load) begin word = cap_d; wok = 1; end
        else begin nxt = cap_d; nxt_v = 1; end
      end
      if (load) begin
        if (!wok) begin
          if (nxt_v) word = nxt;
          else e_ur = 1;
        end
        nxt_v = 0;
        word_cur = word;
      end
      if (ce) e_pixel = act ? word_cur[23 - 4 * (mh % 6) -: 4] : 4'h0;
      // A grant this edge is usable only if its request was raised after the last turnover.
      pend_v = prev_req && gnt;
      pend_d = mem[prev_addr];
      pend_ok = (req_rise > last_turn);
    end
    @(negedge clk);
    if (reset) begin
      check("reset_outs", 32'({rd_req, pixel, de, hsync, vsync, frame_start, underrun}), 0);
    end else begin
      check("pixel", 32'(pixel), 32'(e_pixel));
      check("de", 32'(de), 32'(e_de));
      check("hsync", 32'(hsync), 32'(e_hs));
      check("vsync", 32'(vsync), 32'(e_vs));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      check("underrun", 32'(underrun), 32'(e_ur));
      if (prev_req && gnt) check("req_drop", 32'(rd_req), 0);
      if (rd_req && !prev_req) begin
        req_rise = edge_n;
        trow = (ph >= HA) ? ((pv + 1) % VT) : pv;
        check("req_row_active", 32'(trow < VA), 1);
        check("req_addr", 32'(rd_addr), 32'({fcol[5:0], trow[7:0]}));
      end else if (rd_req && prev_req) begin
        check("addr_hold", 32'(rd_addr), 32'(prev_addr));
      end
      prev_req = rd_req;
      prev_addr = rd_addr;
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    check("reset_req_drop", 32'(rd_req), 0);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0);
    reset = 1'b0;
    model_reset();
  endtask

  int  px [12];
  int  run1, fs_at, first_req, cnt_hs, cnt_vs, cnt_de, cnt_nz, cnt_chg, fs_lat;
  bit  in_run, run_done, found, ce_b;
  logic [6:0] last_outs;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 24'($urandom);
    mem[14'h0000] = 24'h123456;
    mem[14'h0100] = 24'h789ABC;
    model_reset();

    // Normal line with grant tied high.
    do_reset(3);
    run1 = 0; in_run = 0; run_done = 0; fs_at = -1; first_req = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b1);
      if (first_req < 0 && rd_req) begin
        first_req = i;
        check("first_req_addr", 32'(rd_addr), 0);
      end
      if (!run_done) begin
        if (de) begin
          if (run1 < 12) px[run1] = int'(pixel);
          if (frame_start) fs_at = run1;
          run1++;
          in_run = 1;
        end else if (in_run) begin
          run_done = 1;
          check("after_line_pixel", 32'(pixel), 0);
        end
      end
    end
    check("first_req_latency", 32'(first_req >= 1 && first_req <= 2), 1);
    check("de_run_len", run1, 12);
    for (int k = 0; k < 12; k++) check("line0_pixel", px[k], k + 1);
    check("fs_with_px1", fs_at, 0);

    // Grant stall on the row-1 prefetch.
    do_reset(2);
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      step(1'b1, 1'b1);
      if (rd_req && rd_addr == 14'h0001) found = 1;
    end
    check("stall_req_seen", 32'(found), 1);
    if (found) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b1, 1'b0);
        check("stall_req", 32'(rd_req), 1);
        check("stall_addr", 32'(rd_addr), 32'h0001);
      end
    end
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1);
    check("stall_no_underrun", 32'(underrun), 0);

    // Underrun: no grant for a whole frame.
    do_reset(2);
    cnt_de = 0; cnt_nz = 0;
    for (int i = 0; i < 90; i++) begin
      step(1'b1, 1'b0);
      if (de) cnt_de++;
      if (pixel != 4'h0) cnt_nz++;
    end
    check("ur_de_count", cnt_de, 24);
    check("ur_pixel_nonzero", cnt_nz, 0);
    check("ur_flag", 32'(underrun), 1);
    check("ur_req_stuck", 32'({rd_req, rd_addr}), 32'({1'b1, 14'h0000}));

    // Sync timing with pix_ce every other clk.
    do_reset(2);
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_chg = 0;
    last_outs = '0;
    for (int i = 0; i < 2 * 2 * HT * VT; i++) begin
      ce_b = (i % 2 == 0);
      step(ce_b, 1'($urandom_range(0, 1)));
      if (ce_b) begin
        if (hsync) cnt_hs++;
        if (vsync) cnt_vs++;
        if (de) cnt_de++;
      end else if ({pixel, de, hsync, vsync} != last_outs) begin
        cnt_chg++;
      end
      last_outs = {pixel, de, hsync, vsync};
    end
    check("hsync_count", cnt_hs, 20);
    check("vsync_count", cnt_vs, 36);
    check("de_count", cnt_de, 48);
    check("change_off_ce", cnt_chg, 0);

    // Randomised pix_ce density and grant behaviour.
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
    end

    // Reset while a read is in WAIT.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1, 1'b0);
      if (rd_req) found = 1;
    end
    check("wait_req_seen", 32'(found), 1);
    step(1'b1, 1'b1);
    do_reset(2);
    fs_lat = 0;
    for (int i = 1; i <= 20 && fs_lat == 0; i++) begin
      step(1'b1, 1'b1);
      if (frame_start) fs_lat = i;
    end
    check("fs_latency_after_reset", fs_lat, 6);
    for (int i = 0; i < 400; i++) step(1'b1, ($urandom_range(0, 3) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_scanout.md
Name: video_scanout

Overview:
- Read-side client of the 16k x 24 video RAM. Generates raster timing and prefetches one 24-bit word (6 horizontal 4-bit pixels) at a time through a request/grant port.
- Serialises each word into 4-bit pixel indices for the palette/DAC stage.
- Word address = {column[5:0], row[7:0]}, so the frame is up to 384 x 256 pixels.

Parameters:
- H_ACTIVE, 384, visible pixels per line; a multiple of 6, at most 384.
- H_FP, 16, horizontal front-porch pixels.
- H_SYNC, 32, horizontal sync pixels.
- H_BP, 48, horizontal back-porch pixels.
- V_ACTIVE, 256, visible lines; at most 256.
- V_FP, 4, vertical front-porch lines.
- V_SYNC, 4, vertical sync lines.
- V_BP, 16, vertical back-porch lines.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pix_ce  in  1  pixel clock enable; timing advances only on clk edges where pix_ce=1.
- rd_req  out  1  read request to the RAM arbiter.
- rd_addr  out  14  word address, {col, row}.
- rd_grant  in  1  arbiter accepts rd_addr this cycle.
- rd_data  in  24  RAM data, valid the clk after rd_grant.
- pixel  out  4  current pixel index; 0 when de=0.
- de  out  1  display enable.
- hsync  out  1  active-high horizontal sync.
- vsync  out  1  active-high vertical sync.
- frame_start  out  1  one-clk pulse on the first active pixel of a frame.
- underrun  out  1  sticky flag: a word was needed but not fetched.

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is formed likewise.
- h=0 is the first active pixel and v=0 the first active line.
- Counters advance only on pix_ce. h wraps H_TOTAL-1 -> 0 and then v increments, wrapping V_TOTAL-1 -> 0.
- Reset values:
  - h=H_ACTIVE, v=V_TOTAL-1.
  - All outputs 0; FSM IDLE; fcol=0; nxt_valid=0; underrun=0.
- Raster outputs:
  - de=(h<H_ACTIVE && v<V_ACTIVE).
  - hsync=1 for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is the same rule applied to v.
  - pixel, de, hsync, vsync and frame_start are registered, updated together on each pix_ce cycle, and describe the position just counted.
- Serialiser:
  - A 6-phase counter sub advances on each active pixel.
  - At sub=0 the shift register loads from nxt and nxt_valid clears. If nxt_valid=0 at that point, the shift register loads 0 and underrun sets.
  - Pixel order within a word is [23:20] first, down to [3:0] last.
- Fetch FSM:
  - States are IDLE, REQ and WAIT.
  - IDLE -> REQ when all hold: nxt_valid=0, fcol<H_ACTIVE/6, and the target row is below V_ACTIVE.
  - REQ: rd_req=1; rd_addr={fcol, target row}, held stable until rd_grant. REQ -> WAIT on rd_grant.
  - WAIT: capture rd_data into nxt, set nxt_valid, increment fcol, go to IDLE.
- Target row:
  - During horizontal blanking it is (v+1) mod V_TOTAL.
  - During active pixels it is v.
- Line turnover:
  - At the transition h -> H_ACTIVE (blank start), fcol clears to 0 and nxt_valid clears. This prefetches column 0 of the next line during blanking.
  - An outstanding REQ/WAIT completes its handshake, but its data is discarded and fcol stays 0.
- Simultaneous events:
  - If the WAIT capture coincides with a sub=0 load, the captured data goes straight to the shift register, nxt_valid stays 0, and no underrun is flagged.
- Flag and reset rules:
  - underrun clears only on reset.
  - Reset mid-operation drops rd_req immediately; any in-flight rd_data is ignored.
- Throughput: fetching one word takes at least 3 clk, so sustained operation requires pix_ce density of at most 1 in 1 (6 pixels per ≥3 clk).

Test Plan:
- Common setup: small parameters (H_ACTIVE=12, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1), pix_ce=1, and a RAM model with 1-clk read latency.
- Reset: reset held, then released -> all outputs 0. First rd_req appears within 2 clk with rd_addr=0x0000 (col 0, row 0, since the line after reset is v=0).
- Normal line:
  - Stimulus: rd_grant tied 1; mem[0x0000]=0x123456, mem[0x0100]=0x789ABC.
  - Response: line 0 shows pixels 1,2,3,4,5,6,7,8,9,A,B,C with de=1 for exactly 12 cycles, then pixel=0 and de=0.
  - frame_start pulses with pixel 1.
- Grant stall:
  - Stimulus: rd_grant held 0 for 3 clk on the row-1 prefetch.
  - Response: rd_req stays 1 and rd_addr stays 0x0001 throughout; data is still used correctly, with no underrun.
- Underrun:
  - Stimulus: rd_grant held 0 for a whole frame.
  - Response: de and syncs follow normal timing; pixel=0; underrun=1 from the first active pixel and stays 1.
- Sync timing:
  - Stimulus: pix_ce=1 every other clk.
  - Response: hsync=1 for h=14..15; vsync=1 on v=3; outputs change only on pix_ce cycles.
- Reset in WAIT:
  - Stimulus: assert reset on the clk after rd_grant.
  - Response: rd_req=0 and h/v return to reset values; no pixel from that word ever appears.
